rgb2packet: RTL and testbench
=============================

// Module: rgb2packet
// PURPOSE
//  Serializes 24-bit RGB pixels into a byte stream for the byte-to-RGB receiver on the packet link.
//  Pixels enter via valid/ready into an internal sync FIFO. Each pixel leaves as 3 contiguous bytes, LSB first.
//  Sits between pixel pipeline and packet link; the link has no backpressure.
// PARAMETERS
//  FIFO_DEPTH  4  input FIFO entries; power of 2, >=2
//  PIXEL_GAP   0  minimum idle cycles (o_data_valid=0) inserted between pixel groups; 0..15
// PORTS
//  i_clk          in   1   clock; all logic on posedge
//  i_rst          in   1   reset; synchronous, active-high
//  i_rgb_data     in   24  pixel; [7:0] sent first, [15:8] second, [23:16] third
//  i_rgb_valid    in   1   pixel valid; write when i_rgb_valid && o_rgb_ready at posedge
//  o_rgb_ready    out  1   = !fifo_full; registered-count based, no comb path from i_rgb_valid
//  o_data_packet  out  8   byte out, registered
//  o_data_valid   out  1   byte valid, registered
//  o_busy         out  1   FIFO non-empty or FSM not IDLE
// BEHAVIOUR
//  Reset: o_data_packet=0, o_data_valid=0, o_busy=0, o_rgb_ready=1. FIFO flushed, FSM->IDLE, gap counter=0.
//  FSM: IDLE, SEND1, SEND2, SEND3, [SENDP], GAP.
//   IDLE: if FIFO non-empty -> pop into 24b shift reg; drive byte0, valid=1; ->SEND1.
//   SEND1 ->SEND2 (drive byte1); SEND2 ->SEND3 (drive byte2); unconditional, no stalls inside a pixel.
//   SEND3: PIXEL_GAP=0 and FIFO non-empty -> pop, drive next byte0, ->SEND1 (gapless stream).
//          PIXEL_GAP>0 -> valid=0, load gap cnt, ->GAP. Else valid=0, ->IDLE.
//   GAP: valid=0; count down PIXEL_GAP cycles, then ->IDLE.
//  Latency: pixel written at edge k into empty FIFO, idle FSM -> byte0 registered at edge k+1,
//   byte1 at k+2, byte2 at k+3. No FIFO fall-through.
//  Throughput: 1 pixel / (3+PIXEL_GAP) cycles (4+PIXEL_GAP with parity).
//  o_data_packet holds last byte when valid=0; only valid qualifies it.
//  FIFO: count-based, push and pop same edge allowed (count unchanged). Full -> ready=0, no push.
//   Empty -> no pop. Pointers wrap modulo FIFO_DEPTH.
//  Reset mid-pixel: pixel truncated; valid=0 from the next cycle; queued pixels discarded.
//  Byte order within a pixel is fixed; no byte of one pixel interleaves with another.
// CONFIGURATION
//  RGB2PACKET_PARITY_EN defined: extra state SENDP after SEND3 drives check byte =
//   data[7:0]^data[15:8]^data[23:16], valid=1. SENDP then takes SEND3's exit decisions.
//  Undefined: no SENDP, 3 bytes per pixel, SEND3 exits directly.
// STRUCTURE
//  Package rgb_pkt_pkg: typedef logic [23:0] rgb_t; typedef logic [7:0] byte_t;
//   localparam BYTES_PER_PIXEL=3; typedef enum state_t {IDLE,SEND1,SEND2,SEND3,SENDP,GAP}.
//  Sub-module rgb_pkt_fifo (WIDTH, DEPTH): sync FIFO with full/empty/count, same reset.
//  Top holds FSM, shift reg, gap counter, output registers.
// TESTING
//  1. Hold reset 3 cycles -> o_data_valid=0, o_data_packet=0, o_busy=0, o_rgb_ready=1.
//  2. One pixel 0x332211 -> 0x11,0x22,0x33 on 3 consecutive cycles from edge k+1, then valid=0, busy=0.
//  3. FIFO_DEPTH=4, 6 pixels with valid held -> ready drops while full; 18 gapless bytes in order.
//  4. PIXEL_GAP=2, 2 back-to-back pixels -> 3 valid bytes, 2 idle cycles, 3 valid bytes.
//  5. RGB2PACKET_PARITY_EN, pixel 0xA53C0F -> 0x0F,0x3C,0xA5,0x96 contiguous.
//  6. Reset after byte1 with 2 pixels queued -> valid=0 next cycle, busy=0; new pixel 0x030201 -> 01,02,03.

Source files
------------

// File: rtl/rgb_pkt_pkg.sv
// Shared types for the RGB-to-byte serializer: pixel/byte types, the
// serializer state encoding and the check-byte helper.
package rgb_pkt_pkg;

    typedef logic [23:0] rgb_t;
    typedef logic [7:0]  byte_t;

    localparam int BYTES_PER_PIXEL = 3;

    // SENDP is only reachable when the check byte is enabled.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEND1 = 3'd1,
        SEND2 = 3'd2,
        SEND3 = 3'd3,
        SENDP = 3'd4,
        GAP   = 3'd5
    } state_t;

    // XOR of the three colour bytes, appended after the pixel when enabled.
    function automatic byte_t check_byte(input rgb_t p);
        return p[7:0] ^ p[15:8] ^ p[23:16];
    endfunction

endpackage

// File: rtl/rgb_pkt_fifo.sv
// Count-based synchronous FIFO for incoming pixels. Push and pop may occur
// on the same edge; pushes while full and pops while empty are ignored.
// Read data is the entry at the read pointer (no fall-through from wr_data).
module rgb_pkt_fifo
    import rgb_pkt_pkg::*;
#(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = wr_en && !full;
    assign do_pop  = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care after reset since count is zero.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/rgb2packet.sv
// rgb2packet: serializes 24-bit RGB pixels into a byte stream, low byte first.
// Pixels are buffered in rgb_pkt_fifo; the FSM here emits each pixel as
// contiguous bytes on registered outputs, with an optional idle gap between
// pixels (PIXEL_GAP). Defining RGB2PACKET_PARITY_EN appends an XOR check byte
// to every pixel.
//
// Handshake: a pixel is accepted on any rising edge where i_rgb_valid and
// o_rgb_ready are both high. o_rgb_ready is derived only from the registered
// FIFO count, so it never depends combinationally on i_rgb_valid. The byte
// link has no backpressure: o_data_valid qualifies o_data_packet each cycle.
module rgb2packet
    import rgb_pkt_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PIXEL_GAP  = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [23:0] i_rgb_data,
    input  logic        i_rgb_valid,
    output logic        o_rgb_ready,
    output logic [7:0]  o_data_packet,
    output logic        o_data_valid,
    output logic        o_busy
);

    localparam logic [3:0] GAP_LOAD = 4'(PIXEL_GAP);

    logic                        fifo_full;
    logic                        fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    rgb_t                        fifo_rd_data;

    state_t state;
    state_t state_nxt;
    rgb_t   shift_q;
    rgb_t   shift_nxt;
    byte_t  data_q;
    byte_t  data_nxt;
    logic   valid_q;
    logic   valid_nxt;
    logic [3:0] gap_q;
    logic [3:0] gap_nxt;
    logic   pop;
    logic   end_pixel;
    logic   try_start;

    rgb_pkt_fifo #(
        .WIDTH (24),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .wr_en   (i_rgb_valid),
        .wr_data (i_rgb_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign o_rgb_ready   = !fifo_full;
    assign o_data_packet = data_q;
    assign o_data_valid  = valid_q;
    assign o_busy        = (fifo_count != '0) || (state != IDLE);

    // Next-state and next-output logic. try_start is shared by IDLE, an
    // expiring GAP and the end of a gapless pixel so that a queued pixel
    // starts in the same cycle; that makes the gap exactly PIXEL_GAP idle
    // cycles rather than PIXEL_GAP plus an extra IDLE cycle.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_q;
        data_nxt  = data_q;
        valid_nxt = 1'b0;
        gap_nxt   = gap_q;
        pop       = 1'b0;
        end_pixel = 1'b0;
        try_start = 1'b0;

        unique case (state)
            IDLE: begin
                try_start = 1'b1;
            end
            SEND1: begin
                data_nxt  = shift_q[15:8];
                valid_nxt = 1'b1;
                state_nxt = SEND2;
            end
            SEND2: begin
                data_nxt  = shift_q[23:16];
                valid_nxt = 1'b1;
                state_nxt = SEND3;
            end
            SEND3: begin
`ifdef RGB2PACKET_PARITY_EN
                data_nxt  = check_byte(shift_q);
                valid_nxt = 1'b1;
                state_nxt = SENDP;
`else
                end_pixel = 1'b1;
`endif
            end
            SENDP: begin
                end_pixel = 1'b1;
            end
            GAP: begin
                if (gap_q > 4'd1) begin
                    gap_nxt = gap_q - 4'd1;
                end else begin
                    gap_nxt   = 4'd0;
                    try_start = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (end_pixel) begin
            if (PIXEL_GAP > 0) begin
                gap_nxt   = GAP_LOAD;
                state_nxt = GAP;
            end else begin
                try_start = 1'b1;
            end
        end

        if (try_start) begin
            if (!fifo_empty) begin
                pop       = 1'b1;
                shift_nxt = fifo_rd_data;
                data_nxt  = fifo_rd_data[7:0];
                valid_nxt = 1'b1;
                state_nxt = SEND1;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    // State, shift register, gap counter and registered byte outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            gap_q   <= 4'd0;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            gap_q   <= gap_nxt;
        end
    end

endmodule

// File: tb/tb_rgb2packet.sv
// Bench for rgb2packet: directed steps plus a randomized run on a gapless
// instance, and a PIXEL_GAP=2 instance for the gap timing.
module tb_rgb2packet;

`ifdef RGB2PACKET_PARITY_EN
    localparam int BPP = 4;
`else
    localparam int BPP = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] rgb_data;
    logic        rgb_valid;
    logic        rgb_valid_g;
    logic        rdy0, dv0, busy0;
    logic [7:0]  data0;
    logic        rdy_g, dv_g, busy_g;
    logic [7:0]  data_g;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    int          sb_pos = 0;
    logic        acc;
    logic [23:0] pix [6];
    logic [23:0] pa, pb;
    int          run_len;
    logic        run_started, run_ended;

    always #5 clk = ~clk;

    rgb2packet #(.FIFO_DEPTH(4), .PIXEL_GAP(0)) dut (
        .i_clk(clk), .i_rst(rst), .i_rgb_data(rgb_data), .i_rgb_valid(rgb_valid),
        .o_rgb_ready(rdy0), .o_data_packet(data0), .o_data_valid(dv0), .o_busy(busy0)
    );

    rgb2packet #(.FIFO_DEPTH(4), .PIXEL_GAP(2)) dut_gap (
        .i_clk(clk), .i_rst(rst), .i_rgb_data(rgb_data), .i_rgb_valid(rgb_valid_g),
        .o_rgb_ready(rdy_g), .o_data_packet(data_g), .o_data_valid(dv_g), .o_busy(busy_g)
    );

    // Byte idx of a pixel on the link: low, middle, high, then the XOR check byte.
    function automatic logic [7:0] pix_byte(input logic [23:0] p, input int idx);
        case (idx)
            0:       return p[7:0];
            1:       return p[15:8];
            2:       return p[23:16];
            default: return p[7:0] ^ p[15:8] ^ p[23:16];
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: model acceptance with pre-edge values, then score dut's byte stream.
    task automatic tick();
        logic r;
        @(posedge clk);
        r = rst;
        if (r) begin
            exp_q.delete();
            sb_pos = 0;
        end else if (rgb_valid && rdy0) begin
            for (int b = 0; b < BPP; b++) exp_q.push_back(pix_byte(rgb_data, b));
        end
        #1;
        if (!r) begin
            if (dv0) begin
                check("sb_byte_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("sb_byte", 32'(data0), 32'(exp_q.pop_front()));
                    sb_pos = (sb_pos + 1) % BPP;
                end
            end else begin
                check("sb_pixel_contiguous", 32'(sb_pos == 0), 32'd1);
            end
        end
    endtask

    task automatic obs_run();
        if (dv0) begin
            run_len++;
            run_started = 1'b1;
        end else if (run_started) begin
            run_ended = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b1; rgb_valid = 1'b0; rgb_valid_g = 1'b0; rgb_data = '0;

        // 1. reset held three cycles
        tick(); tick(); tick();
        check("rst_valid", 32'(dv0), 32'd0);
        check("rst_data", 32'(data0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_ready", 32'(rdy0), 32'd1);
        check("rst_g_valid", 32'(dv_g), 32'd0);
        check("rst_g_ready", 32'(rdy_g), 32'd1);
        rst = 1'b0;
        tick();

        // 2. single pixel, latency k+1..k+BPP
        rgb_data = 24'h332211; rgb_valid = 1'b1;
        tick();
        rgb_valid = 1'b0;
        check("t2_no_fallthrough", 32'(dv0), 32'd0);
        check("t2_busy_queued", 32'(busy0), 32'd1);
        for (int b = 0; b < BPP; b++) begin
            tick();
            check("t2_valid", 32'(dv0), 32'd1);
            check("t2_byte", 32'(data0), 32'(pix_byte(24'h332211, b)));
        end
        tick();
        check("t2_valid_after", 32'(dv0), 32'd0);
        check("t2_busy_after", 32'(busy0), 32'd0);
        check("t2_hold_last", 32'(data0), 32'(pix_byte(24'h332211, BPP-1)));

        // 3. six pixels with valid held: all accepted on consecutive edges, FIFO then full
        run_len = 0; run_started = 1'b0; run_ended = 1'b0;
        for (int i = 0; i < 6; i++) pix[i] = 24'($urandom());
        for (int i = 0; i < 6; i++) begin
            check("t3_ready_before_push", 32'(rdy0), 32'd1);
            rgb_data = pix[i]; rgb_valid = 1'b1;
            tick();
            obs_run();
        end
        rgb_valid = 1'b0;
        check("t3_ready_full", 32'(rdy0), 32'd0);
        for (int c = 0; c < 60 && !run_ended; c++) begin
            tick();
            obs_run();
        end
        check("t3_run_ended", 32'(run_ended), 32'd1);
        check("t3_gapless_bytes", 32'(run_len), 32'(6 * BPP));
        check("t3_ready_back", 32'(rdy0), 32'd1);

        // 4. PIXEL_GAP=2 instance, two back-to-back pixels
        pa = 24'($urandom()); pb = 24'($urandom());
        rgb_data = pa; rgb_valid_g = 1'b1;
        tick();
        rgb_data = pb;
        tick();
        rgb_valid_g = 1'b0;
        for (int b = 0; b < BPP; b++) begin
            if (b > 0) tick();
            check("t4_a_valid", 32'(dv_g), 32'd1);
            check("t4_a_byte", 32'(data_g), 32'(pix_byte(pa, b)));
        end
        for (int g = 0; g < 2; g++) begin
            tick();
            check("t4_gap_idle", 32'(dv_g), 32'd0);
        end
        for (int b = 0; b < BPP; b++) begin
            tick();
            check("t4_b_valid", 32'(dv_g), 32'd1);
            check("t4_b_byte", 32'(data_g), 32'(pix_byte(pb, b)));
        end
        tick();
        check("t4_idle_after", 32'(dv_g), 32'd0);
        for (int c = 0; c < 20 && busy_g; c++) tick();
        check("t4_busy_clear", 32'(busy_g), 32'd0);

`ifdef RGB2PACKET_PARITY_EN
        // 5. check byte
        rgb_data = 24'hA53C0F; rgb_valid = 1'b1;
        tick();
        rgb_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            tick();
            check("t5_valid", 32'(dv0), 32'd1);
            check("t5_byte", 32'(data0), 32'(b == 0 ? 8'h0F : b == 1 ? 8'h3C : b == 2 ? 8'hA5 : 8'h96));
        end
        tick();
        check("t5_valid_after", 32'(dv0), 32'd0);
`endif

        // 6. reset after byte1 with two pixels queued
        for (int c = 0; c < 40 && busy0; c++) tick();
        check("t6_idle_start", 32'(busy0), 32'd0);
        pa = 24'($urandom());
        rgb_data = pa; rgb_valid = 1'b1;
        tick();
        rgb_data = 24'($urandom());
        tick();
        check("t6_byte0", 32'(data0), 32'(pix_byte(pa, 0)));
        rgb_data = 24'($urandom());
        tick();
        check("t6_byte1", 32'(data0), 32'(pix_byte(pa, 1)));
        rgb_valid = 1'b0; rst = 1'b1;
        tick();
        check("t6_rst_valid", 32'(dv0), 32'd0);
        check("t6_rst_busy", 32'(busy0), 32'd0);
        check("t6_rst_ready", 32'(rdy0), 32'd1);
        check("t6_rst_data", 32'(data0), 32'd0);
        rst = 1'b0;
        tick();
        check("t6_no_stale", 32'(dv0), 32'd0);
        rgb_data = 24'h030201; rgb_valid = 1'b1;
        tick();
        rgb_valid = 1'b0;
        for (int b = 0; b < BPP; b++) begin
            tick();
            check("t6_new_valid", 32'(dv0), 32'd1);
            check("t6_new_byte", 32'(data0), 32'(pix_byte(24'h030201, b)));
        end

        // Randomized traffic, scored by the expected-byte queue
        for (int p = 0; p < 40; p++) begin
            rgb_data = 24'($urandom());
            for (int t = 0; t < 50; t++) begin
                rgb_valid = ($urandom_range(0, 3) != 0);
                acc = rgb_valid && rdy0;
                tick();
                if (acc) break;
            end
        end
        rgb_valid = 1'b0;
        for (int c = 0; c < 400 && (busy0 || exp_q.size() != 0); c++) tick();
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("drain_busy", 32'(busy0), 32'd0);
        check("drain_valid", 32'(dv0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
